// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - end-of-run data memory dump reader
//
// Waits for the halt word on the ID-stage instruction, lets the pipeline
// drain, then owns the memory read port and streams NUM_WORDS words out on
// a valid/ready interface. A watchdog ends the run if no halt ever arrives.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   INSTR_D[31:0]         ID-stage instruction, watched for the halt word
//   MEM_SEL               1 while this block drives the memory address mux
//   MEM_ADDR[31:0]        word address presented to memory
//   MEM_RDATA[31:0]       combinational read data for MEM_ADDR
//   OUT_VALID/OUT_READY   output word handshake
//   OUT_DATA[31:0]        dumped word
//   OUT_INDEX[IDX_W-1:0]  index of OUT_DATA within the dump
//   DONE                  sticky, dump finished or watchdog fired
//   TIMEOUT               sticky, watchdog fired before a halt was seen
module mem_dump_reader #(
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned NUM_WORDS    = 50,
  parameter logic [31:0] BASE_ADDR    = 32'd0,
  parameter int unsigned MAX_CYCLES   = 200,
  parameter int unsigned IDX_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      INSTR_D,
  output logic             MEM_SEL,
  output logic [31:0]      MEM_ADDR,
  input  logic [31:0]      MEM_RDATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_DATA,
  output logic [IDX_W-1:0] OUT_INDEX,
  output logic             DONE,
  output logic             TIMEOUT
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    SEND,
    FIN
  } state_t;

  localparam logic [31:0]      HALT_WORD  = 32'hFFFF_FFFF;
  localparam logic [31:0]      WD_LAST    = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_t           state;
  logic [31:0]      cyc_cnt;
  logic [31:0]      drain_cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cyc_cnt   <= 32'd0;
      drain_cnt <= 32'd0;
      idx       <= '0;
      MEM_SEL   <= 1'b0;
      MEM_ADDR  <= 32'd0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= 32'd0;
      OUT_INDEX <= '0;
      DONE      <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Halt detection takes priority over a watchdog expiring on the same edge.
          if (INSTR_D == HALT_WORD) begin
            state     <= DRAIN;
            drain_cnt <= 32'd0;
          end else if (cyc_cnt == WD_LAST) begin
            state   <= FIN;
            DONE    <= 1'b1;
            TIMEOUT <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        DRAIN: begin
          // MEM_SEL/MEM_ADDR are registered, so they are set up on the way
          // into READ and are already valid during the READ cycle.
          if (drain_cnt == DRAIN_LAST) begin
            state    <= READ;
            MEM_SEL  <= 1'b1;
            MEM_ADDR <= BASE_ADDR + 32'(idx);
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        READ: begin
          OUT_DATA  <= MEM_RDATA;
          OUT_INDEX <= idx;
          OUT_VALID <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (idx == LAST_IDX) begin
              state   <= FIN;
              DONE    <= 1'b1;
              MEM_SEL <= 1'b0;
            end else begin
              idx      <= idx + IDX_ONE;
              MEM_ADDR <= BASE_ADDR + 32'(idx) + 32'd1;
              state    <= READ;
            end
          end
        end
        FIN: begin
          DONE      <= 1'b1;
          MEM_SEL   <= 1'b0;
          OUT_VALID <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - scoreboard bench for mem_dump_reader
`timescale 1ns/1ps
module tb_mem_dump_reader;

  localparam int D = 5;
  localparam int N = 50;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_sel, out_valid, out_ready, done, timeout;
  logic [31:0] mem_addr, mem_rdata, out_data;
  logic [7:0]  out_index;

  logic        rst6 = 1'b1;
  logic [31:0] instr6 = 32'd0;
  logic        mem_sel6, out_valid6, out_ready6, done6, timeout6;
  logic [31:0] mem_addr6, mem_rdata6, out_data6;
  logic [7:0]  out_index6;

  assign mem_rdata  = mem_addr * 32'd3;
  assign mem_rdata6 = mem_addr6 * 32'd3;
  assign out_ready6 = 1'b1;

  mem_dump_reader u_dut (
    .CLK(clk), .RESET(rst), .INSTR_D(instr),
    .MEM_SEL(mem_sel), .MEM_ADDR(mem_addr), .MEM_RDATA(mem_rdata),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .OUT_INDEX(out_index), .DONE(done), .TIMEOUT(timeout)
  );

  mem_dump_reader #(.BASE_ADDR(32'hFFFF_FFFE), .NUM_WORDS(4)) u_dut6 (
    .CLK(clk), .RESET(rst6), .INSTR_D(instr6),
    .MEM_SEL(mem_sel6), .MEM_ADDR(mem_addr6), .MEM_RDATA(mem_rdata6),
    .OUT_VALID(out_valid6), .OUT_READY(out_ready6), .OUT_DATA(out_data6),
    .OUT_INDEX(out_index6), .DONE(done6), .TIMEOUT(timeout6)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t q6[$];
  exp_t e;
  exp_t e6;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int acc_base = 0;
  int valid_cnt = 0;
  int sel_cnt = 0;
  int ready_mode = 0;

  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1, hs;
  logic [31:0] prev_data = 32'd0;
  logic [7:0]  prev_idx = 8'd0;

  // Ready generator: 0 = always ready, 1 = ready one cycle in three,
  // 2 = ready until 20 words of the current dump have been accepted.
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          out_ready = (ph == 2);
          ph = (ph + 1) % 3;
        end
        2: out_ready = ((acc_cnt - acc_base) < 20);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled word neither drops nor changes.
  always @(negedge clk) begin
    if (out_valid) valid_cnt++;
    if (mem_sel) sel_cnt++;
    if (prev_valid && !prev_hs && !prev_rst) begin
      checks++;
      if (!out_valid || out_data !== prev_data || out_index !== prev_idx) begin
        errors++;
        $display("FAIL stall_stable got valid=%0b data=%h idx=%0d required valid=1 data=%h idx=%0d",
                 out_valid, out_data, out_index, prev_data, prev_idx);
      end
    end
    hs = out_valid && out_ready;
    if (hs) begin
      acc_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got data=%h idx=%0d required no handshake", out_data, out_index);
      end else begin
        e = q.pop_front();
        if (out_data !== e.data || out_index !== e.idx || mem_addr !== e.addr || mem_sel !== 1'b1) begin
          errors++;
          $display("FAIL word got data=%h idx=%0d addr=%h sel=%0b required data=%h idx=%0d addr=%h sel=1",
                   out_data, out_index, mem_addr, mem_sel, e.data, e.idx, e.addr);
        end
      end
    end
    prev_valid = out_valid;
    prev_hs    = hs;
    prev_rst   = rst;
    prev_data  = out_data;
    prev_idx   = out_index;

    if (out_valid6 && out_ready6) begin
      checks++;
      if (q6.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word6 got data=%h idx=%0d required no handshake", out_data6, out_index6);
      end else begin
        e6 = q6.pop_front();
        if (out_data6 !== e6.data || out_index6 !== e6.idx || mem_addr6 !== e6.addr) begin
          errors++;
          $display("FAIL word6 got data=%h idx=%0d addr=%h required data=%h idx=%0d addr=%h",
                   out_data6, out_index6, mem_addr6, e6.data, e6.idx, e6.addr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_dump(input int count);
    for (int i = 0; i < count; i++)
      q.push_back('{data: 32'(i * 3), idx: 8'(i), addr: 32'(i)});
  endtask

  // Called in cycle 0 after reset; the halt word is sampled at edge h.
  task automatic halt_at(input int h, input bit second);
    repeat (h - 1) @(posedge clk);
    #1;
    if (second) instr6 = HALT; else instr = HALT;
    @(posedge clk);
    #1;
    instr6 = 32'd0;
    instr  = 32'd0;
  endtask

  task automatic wait_done(input string name, input int limit, input bit second);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((second ? done6 : done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_sel"}, 32'(mem_sel), 32'd0);
    check({name, "_addr"}, mem_addr, 32'd0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_data"}, out_data, 32'd0);
    check({name, "_index"}, 32'(out_index), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int vc0, sc0;
    bit found;

    // T1: halt at cycle 10, always ready
    do_reset();
    @(negedge clk);
    check_zero("t1_reset");
    push_dump(N);
    halt_at(10, 1'b0);
    repeat (D - 1) @(posedge clk);
    @(negedge clk);
    check("t1_sel_before_read", 32'(mem_sel), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_sel_at_read", 32'(mem_sel), 32'd1);
    check("t1_addr_at_read", mem_addr, 32'd0);
    check("t1_valid_at_read", 32'(out_valid), 32'd0);
    wait_done("t1_done", 400, 1'b0);
    check("t1_timeout", 32'(timeout), 32'd0);
    check("t1_queue_empty", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_done_sticky", 32'(done), 32'd1);
    check("t1_fin_sel", 32'(mem_sel), 32'd0);
    check("t1_fin_valid", 32'(out_valid), 32'd0);

    // T2: ready one cycle in three
    ready_mode = 1;
    do_reset();
    push_dump(N);
    halt_at(10, 1'b0);
    wait_done("t2_done", 600, 1'b0);
    check("t2_timeout", 32'(timeout), 32'd0);
    check("t2_queue_empty", 32'(q.size()), 32'd0);
    ready_mode = 0;

    // T3: no halt, watchdog fires after 200 cycles
    do_reset();
    vc0 = valid_cnt;
    sc0 = sel_cnt;
    repeat (199) @(posedge clk);
    @(negedge clk);
    check("t3_done_before", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t3_done", 32'(done), 32'd1);
    check("t3_timeout", 32'(timeout), 32'd1);
    repeat (5) @(negedge clk);
    check("t3_done_sticky", 32'(done), 32'd1);
    check("t3_valid_never", 32'(valid_cnt - vc0), 32'd0);
    check("t3_sel_never", 32'(sel_cnt - sc0), 32'd0);

    // T4: reset while stalled in SEND at index 20, then full restart
    acc_base = acc_cnt;
    ready_mode = 2;
    do_reset();
    push_dump(20);
    halt_at(10, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_index === 8'd20) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_reach_idx20", 32'(found), 32'd1);
    check("t4_no_hs_at_20", 32'(out_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check_zero("t4_after_reset");
    check("t4_queue_empty", 32'(q.size()), 32'd0);
    push_dump(N);
    halt_at(10, 1'b0);
    wait_done("t4_done", 400, 1'b0);
    check("t4_restart_queue_empty", 32'(q.size()), 32'd0);

    // T5: halt on the same edge the watchdog expires
    do_reset();
    push_dump(N);
    halt_at(200, 1'b0);
    @(negedge clk);
    check("t5_timeout_after_halt", 32'(timeout), 32'd0);
    check("t5_done_after_halt", 32'(done), 32'd0);
    wait_done("t5_done", 400, 1'b0);
    check("t5_timeout", 32'(timeout), 32'd0);
    check("t5_queue_empty", 32'(q.size()), 32'd0);

    // T6: base address wraps through 2**32
    @(posedge clk);
    #1 rst6 = 1'b1;
    @(posedge clk);
    #1 rst6 = 1'b0;
    @(negedge clk);
    check("t6_reset_done", 32'(done6), 32'd0);
    check("t6_reset_sel", 32'(mem_sel6), 32'd0);
    q6.push_back('{data: 32'hFFFF_FFFA, idx: 8'd0, addr: 32'hFFFF_FFFE});
    q6.push_back('{data: 32'hFFFF_FFFD, idx: 8'd1, addr: 32'hFFFF_FFFF});
    q6.push_back('{data: 32'h0000_0000, idx: 8'd2, addr: 32'h0000_0000});
    q6.push_back('{data: 32'h0000_0003, idx: 8'd3, addr: 32'h0000_0001});
    halt_at(10, 1'b1);
    repeat (D - 1) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t6_first_addr", mem_addr6, 32'hFFFF_FFFE);
    wait_done("t6_done", 100, 1'b1);
    check("t6_timeout", 32'(timeout6), 32'd0);
    check("t6_queue_empty", 32'(q6.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
